// File: rtl/gpu_pkg.sv
// Shared types for the kernel dispatcher: kernel/slot state encodings and block id width.
// Pure declarations, no logic.
package gpu_pkg;
    localparam int BLOCK_ID_W = 8;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_RUN  = 2'd1,
        K_DONE = 2'd2
    } kstate_t;

    typedef enum logic [1:0] {
        C_RELEASE = 2'd0,
        C_READY   = 2'd1,
        C_RUN     = 2'd2
    } cstate_t;
endpackage

// File: rtl/dispatch_core_slot.sv
// One core slot: release -> ready -> run handshake with its registered block assignment.
// Grant is accepted only in C_READY; a retiring core always passes one reset cycle first.
module dispatch_core_slot
    import gpu_pkg::*;
#(
    parameter int TCW = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  grant,
    input  logic [BLOCK_ID_W-1:0] grant_block_id,
    input  logic [TCW-1:0]        grant_thread_count,
    input  logic                  core_done,
    output logic                  ready,
    output logic                  retire,
    output logic                  core_start,
    output logic                  core_reset,
    output logic [BLOCK_ID_W-1:0] block_id,
    output logic [TCW-1:0]        thread_count
);
    cstate_t state, state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= C_RELEASE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            C_RELEASE: state_next = C_READY;
            C_READY:   if (grant) state_next = C_RUN;
            C_RUN:     if (core_done) state_next = C_RELEASE;
            default:   state_next = C_RELEASE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            block_id     <= '0;
            thread_count <= '0;
        end else if (grant && state == C_READY) begin
            block_id     <= grant_block_id;
            thread_count <= grant_thread_count;
        end
    end

    assign ready      = (state == C_READY);
    assign retire     = (state == C_RUN) && core_done;
    assign core_start = (state == C_RUN);
    assign core_reset = (state == C_RELEASE);
endmodule

// File: rtl/block_dispatcher.sv
// Splits a launched kernel into thread blocks and hands them to the core array, one grant per cycle.
// Lowest-index ready core wins; kernel done once every dispatched block has retired.
module block_dispatcher
    import gpu_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 start,
    input  logic [7:0]                                           thread_count,
    output logic [NUM_CORES-1:0]                                 core_start,
    output logic [NUM_CORES-1:0]                                 core_reset,
    output logic [BLOCK_ID_W*NUM_CORES-1:0]                      core_block_id,
    output logic [($clog2(THREADS_PER_BLOCK)+1)*NUM_CORES-1:0]   core_thread_count,
    input  logic [NUM_CORES-1:0]                                 core_done,
    output logic                                                 done
);
    localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int TCW      = LOG2_TPB + 1;

    kstate_t kstate, kstate_next;

    logic [7:0]           tc_q;
    logic [8:0]           total_blocks;
    logic [8:0]           dispatched;
    logic [8:0]           retired;
    logic [8:0]           blocks_calc;
    logic [15:0]          offset;
    logic [15:0]          remaining;
    logic [TCW-1:0]       grant_tc;
    logic                 can_grant;
    logic                 grant_any;
    logic [NUM_CORES-1:0] grant_vec;
    logic [NUM_CORES-1:0] ready_vec;
    logic [NUM_CORES-1:0] retire_vec;
    logic [3:0]           retire_cnt;

    assign blocks_calc = 9'(({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB);

    // The last block may be partial; everything before it is full.
    assign offset    = 16'(dispatched) << LOG2_TPB;
    assign remaining = {8'd0, tc_q} - offset;
    assign grant_tc  = (remaining >= 16'(THREADS_PER_BLOCK)) ? TCW'(THREADS_PER_BLOCK)
                                                             : remaining[TCW-1:0];

    assign can_grant = (kstate == K_RUN) && (dispatched < total_blocks);

    always_comb begin
        logic found;
        found     = 1'b0;
        grant_vec = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (can_grant && ready_vec[i] && !found) begin
                grant_vec[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign grant_any = |grant_vec;

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            retire_cnt = retire_cnt + 4'(retire_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kstate <= K_IDLE;
        end else begin
            kstate <= kstate_next;
        end
    end

    always_comb begin
        kstate_next = kstate;
        case (kstate)
            K_IDLE:  if (start) kstate_next = K_RUN;
            K_RUN:   if (retired == total_blocks) kstate_next = K_DONE;
            K_DONE:  if (!start) kstate_next = K_IDLE;
            default: kstate_next = K_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tc_q         <= '0;
            total_blocks <= '0;
            dispatched   <= '0;
            retired      <= '0;
        end else if (kstate == K_IDLE) begin
            if (start) begin
                tc_q         <= thread_count;
                total_blocks <= blocks_calc;
                dispatched   <= '0;
                retired      <= '0;
            end
        end else if (kstate == K_RUN) begin
            if (grant_any) begin
                dispatched <= dispatched + 9'd1;
            end
            retired <= retired + 9'(retire_cnt);
        end
    end

    assign done = (kstate == K_DONE);

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        dispatch_core_slot #(
            .TCW(TCW)
        ) u_slot (
            .clk                (clk),
            .reset              (reset),
            .grant              (grant_vec[g]),
            .grant_block_id     (dispatched[BLOCK_ID_W-1:0]),
            .grant_thread_count (grant_tc),
            .core_done          (core_done[g]),
            .ready              (ready_vec[g]),
            .retire             (retire_vec[g]),
            .core_start         (core_start[g]),
            .core_reset         (core_reset[g]),
            .block_id           (core_block_id[g*BLOCK_ID_W +: BLOCK_ID_W]),
            .thread_count       (core_thread_count[g*TCW +: TCW])
        );
    end
endmodule

// File: tb/tb_block_dispatcher.sv
// Randomized bench: behavioural cores react to core_start, a cycle-level kernel model predicts every output.
module tb_block_dispatcher;
    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TCW = $clog2(TPB) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        thread_count;
    logic [NC-1:0]     core_start;
    logic [NC-1:0]     core_reset;
    logic [8*NC-1:0]   core_block_id;
    logic [TCW*NC-1:0] core_thread_count;
    logic [NC-1:0]     core_done;
    logic              done;

    block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .core_done         (core_done),
        .done              (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: kernel phase 0=idle 1=running 2=done; a core is grantable from edge m_avail on.
    int m_kphase = 0;
    int m_tc = 0, m_total = 0, m_disp = 0, m_ret = 0;
    int m_run   [NC];
    int m_avail [NC];
    int m_bid   [NC];
    int m_tcnt  [NC];
    int cyc = 0;

    task automatic model_step();
        int gi;
        int nphase;
        if (reset) begin
            for (int i = 0; i < NC; i++) begin
                m_run[i] = 0; m_avail[i] = cyc + 2; m_bid[i] = 0; m_tcnt[i] = 0;
            end
            m_kphase = 0; m_tc = 0; m_total = 0; m_disp = 0; m_ret = 0;
        end else begin
            gi = -1;
            nphase = m_kphase;
            if (m_kphase == 1 && m_disp < m_total)
                for (int i = 0; i < NC; i++)
                    if (gi < 0 && m_run[i] == 0 && cyc >= m_avail[i]) gi = i;
            if (m_kphase == 1 && m_ret == m_total) nphase = 2;
            if (m_kphase == 2 && !start) nphase = 0;
            if (m_kphase == 1) begin
                for (int i = 0; i < NC; i++)
                    if (m_run[i] != 0 && core_done[i]) begin
                        m_run[i] = 0; m_avail[i] = cyc + 2; m_ret++;
                    end
            end
            if (gi >= 0) begin
                m_run[gi]  = 1;
                m_bid[gi]  = m_disp;
                m_tcnt[gi] = (m_tc - m_disp * TPB < TPB) ? m_tc - m_disp * TPB : TPB;
                m_disp++;
            end
            if (m_kphase == 0 && start) begin
                nphase  = 1;
                m_tc    = thread_count;
                m_total = (m_tc + TPB - 1) / TPB;
                m_disp  = 0;
                m_ret   = 0;
            end
            m_kphase = nphase;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            for (int i = 0; i < NC; i++) begin
                chk("core_start", 32'(core_start[i]), 32'(m_run[i]));
                chk("core_reset", 32'(core_reset[i]),
                    32'((m_run[i] == 0 && m_avail[i] > cyc + 1) ? 1 : 0));
                chk("block_id", 32'(core_block_id[i*8 +: 8]), 32'(m_bid[i]));
                chk("thread_cnt", 32'(core_thread_count[i*TCW +: TCW]), 32'(m_tcnt[i]));
            end
            chk("done", 32'(done), 32'((m_kphase == 2) ? 1 : 0));
            cyc++;
        end
    end

    // Behavioural cores: raise done lat cycles into a run, optional spurious done while not running.
    int fixed_lat [NC];
    int lat       [NC];
    int rc        [NC];
    bit spurious_en = 1'b0;

    initial begin
        core_done = '0;
        for (int i = 0; i < NC; i++) begin
            fixed_lat[i] = 0; lat[i] = 1; rc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    rc[i]++;
                    core_done[i] = (rc[i] >= lat[i]);
                end else begin
                    rc[i]  = 0;
                    lat[i] = (fixed_lat[i] != 0) ? fixed_lat[i] : int'($urandom_range(1, 6));
                    core_done[i] = spurious_en && ($urandom_range(0, 7) == 0);
                end
            end
        end
    end

    task automatic set_lat(input int l0, input int l1);
        fixed_lat[0] = l0;
        fixed_lat[1] = l1;
    endtask

    task automatic kernel(input int tc, input bit drop_mid);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        thread_count = 8'(tc);
        start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (drop_mid && i == 2) start = 1'b0;
            if (m_kphase == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("kernel_completes", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        thread_count = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        set_lat(5, 5);  kernel(8, 1'b0);
        set_lat(3, 3);  kernel(10, 1'b0);
        set_lat(0, 0);  kernel(0, 1'b0);
        set_lat(4, 3);  kernel(16, 1'b0);

        // Abort mid-kernel, then relaunch from block 0.
        set_lat(0, 0);
        @(negedge clk);
        thread_count = 8'd16;
        start = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        kernel(16, 1'b0);

        spurious_en = 1'b1;
        kernel(12, 1'b1);
        kernel(1, 1'b0);
        kernel(255, 1'b0);
        for (int k = 0; k < 14; k++) begin
            kernel(int'($urandom_range(0, 40)), bit'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
